// File: rtl/simple_bus_arbiter.sv
// rtl/simple_bus_arbiter.sv - round-robin arbiter/sequencer sharing one single-beat bus slave; ARB_TIMEOUT_EN adds an m_ready timeout
module simple_bus_arbiter #(
  parameter int N_REQ          = 4,
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int RD_LAT         = 1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ-1:0]      req_we,
  input  logic [N_REQ*AW-1:0]   req_addr,
  input  logic [N_REQ*DW-1:0]   req_wdata,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [DW-1:0]         rsp_rdata,
  output logic                  rsp_err,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_we,
  output logic [AW-1:0]         m_addr,
  output logic [DW-1:0]         m_wdata,
  input  logic [DW-1:0]         m_rdata
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]    state;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] owner;
  logic [IW-1:0] grant_idx;
  logic [IW-1:0] cand;
  logic          grant_found;
  logic [LW-1:0] wait_cnt;

  logic accept;
  logic handshake;
  logic wait_done;
  logic rd_capture;
  logic timeout_hit;

  // Round-robin search: first asserted req_valid above the last grant, wrapping
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last_grant;
    cand        = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IW'((int'(last_grant) + k) % N_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign accept    = (state == IDLE) && grant_found;
  assign handshake = (state == ISSUE) && m_valid && m_ready;
  assign wait_done = (state == WAIT) && (wait_cnt == LW'(RD_LAT));
  // Read data is taken in the handshake cycle itself only when the slave is combinational
  assign rd_capture = (handshake && !m_we && (RD_LAT == 0)) || wait_done;

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt;
  logic          to_resp;

  assign timeout_hit = (state == ISSUE) && m_valid && !m_ready &&
                       (to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign to_resp     = (handshake && (m_we || (RD_LAT == 0))) || wait_done || timeout_hit;

  // Stall counter: cycles m_valid has been refused, restarted for every new transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (accept) begin
      to_cnt <= '0;
    end else if ((state == ISSUE) && m_valid && !m_ready) begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

  // Error flag is refreshed with every response and held until the next one
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_err <= 1'b0;
    end else if (to_resp) begin
      rsp_err <= timeout_hit;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  // Transaction sequencer: one request in flight from accept to response
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) state <= ISSUE;
        end
        ISSUE: begin
          if (handshake) begin
            state <= (m_we || (RD_LAT == 0)) ? RESP : WAIT;
          end else if (timeout_hit) begin
            state <= RESP;
          end
        end
        WAIT: begin
          if (wait_done) state <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Last-grant pointer; reset value puts requester 0 first in line
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= IW'(N_REQ - 1);
    end else if (accept) begin
      last_grant <= grant_idx;
    end
  end

  // Latch the winning request; these registers drive the downstream fields directly
  always_ff @(posedge clk) begin
    if (rst) begin
      owner   <= '0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else if (accept) begin
      owner   <= grant_idx;
      m_we    <= req_we[grant_idx];
      m_addr  <= req_addr[int'(grant_idx)*AW +: AW];
      m_wdata <= req_wdata[int'(grant_idx)*DW +: DW];
    end
  end

  // Downstream valid: raised after accept, dropped after handshake or timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
    end else if (accept) begin
      m_valid <= 1'b1;
    end else if (handshake || timeout_hit) begin
      m_valid <= 1'b0;
    end
  end

  // Read-latency counter: value k during the k-th cycle after the handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (handshake) begin
      wait_cnt <= LW'(1);
    end else if ((state == WAIT) && !wait_done) begin
      wait_cnt <= wait_cnt + LW'(1);
    end
  end

  // Response data: loaded on the way into RESP and held until the next response
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_rdata <= '0;
    end else if (rd_capture) begin
      rsp_rdata <= m_rdata;
    end else if ((handshake && m_we) || timeout_hit) begin
      rsp_rdata <= '0;
    end
  end

  // Accept strobe is combinational in IDLE so the requester sees it in the grant cycle
  always_comb begin
    req_ready = '0;
    if (accept && !rst) req_ready[grant_idx] = 1'b1;
  end

  // One-cycle response pulse to the owner of the finished transaction
  always_comb begin
    rsp_valid = '0;
    if ((state == RESP) && !rst) rsp_valid[owner] = 1'b1;
  end

endmodule

// File: tb/tb_simple_bus_arbiter.sv
// tb/tb_simple_bus_arbiter.sv - self-checking bench for simple_bus_arbiter with an in-bench transaction model
module tb_simple_bus_arbiter;

  localparam int N_REQ  = 4;
  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int RD_LAT = 1;
  localparam int TO     = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    req_we;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*DW-1:0] req_wdata;
  logic [N_REQ-1:0]    rsp_valid;
  logic [DW-1:0]       rsp_rdata;
  logic                rsp_err;
  logic                m_valid;
  logic                m_ready;
  logic                m_we;
  logic [AW-1:0]       m_addr;
  logic [DW-1:0]       m_wdata;
  logic [DW-1:0]       m_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  simple_bus_arbiter #(
    .N_REQ(N_REQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_valid(m_valid), .m_ready(m_ready), .m_we(m_we),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave memory and expected-transaction model
  logic [DW-1:0] mem [logic [AW-1:0]];

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return '0;
  endfunction

  function automatic int rr_pick(input int ptr, input logic [N_REQ-1:0] v);
    for (int k = 1; k <= N_REQ; k++)
      if (v[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
    return -1;
  endfunction

  bit            mb_busy = 0;
  bit            mb_hs, mb_to, mb_we, mb_err = 0, pend_err;
  int            mb_ptr = N_REQ - 1, mb_owner, mb_T, mb_stall, mb_rsp_cyc = -1;
  logic [AW-1:0] mb_addr;
  logic [DW-1:0] mb_wdata, mb_rdata = '0, pend_rdata;
  int            rd_due = -1;
  logic [DW-1:0] rd_val;

  // Slave read port: correct data only in the cycle it is due, noise otherwise
  initial begin
    m_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (RD_LAT == 0) m_rdata = mem_rd(m_addr);
      else if (cyc == rd_due) m_rdata = rd_val;
      else m_rdata = $urandom;
    end
  end

  // Compare every cycle against the model, then advance the model
  always @(negedge clk) begin
    int g;
    bit exp_mv;
    logic [N_REQ-1:0] exp_ready, exp_rsp;
    if (rst) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      mb_busy = 0; mb_ptr = N_REQ - 1; mb_rdata = '0; mb_err = 0;
      rd_due = -1; mb_rsp_cyc = -1;
    end else begin
      exp_ready = '0;
      exp_rsp   = '0;
      g = mb_busy ? -1 : rr_pick(mb_ptr, req_valid);
      if (g >= 0) exp_ready[g] = 1'b1;
      exp_mv = mb_busy && (cyc > mb_T) && !mb_hs && !mb_to;
      if (mb_busy && cyc == mb_rsp_cyc) begin
        exp_rsp[mb_owner] = 1'b1;
        mb_rdata = pend_rdata;
        mb_err   = pend_err;
      end
      chk("req_ready", req_ready, exp_ready);
      chk("rsp_valid", rsp_valid, exp_rsp);
      chk("m_valid", m_valid, exp_mv);
      chk("rsp_rdata", rsp_rdata, mb_rdata);
      chk("rsp_err", rsp_err, mb_err);
      if (exp_mv) begin
        chk("m_we", m_we, mb_we);
        chk("m_addr", m_addr, mb_addr);
        chk("m_wdata", m_wdata, mb_wdata);
        if (m_ready) begin
          mb_hs = 1;
          pend_err = 0;
          if (mb_we) begin
            mem[mb_addr] = mb_wdata;
            pend_rdata = '0;
            mb_rsp_cyc = cyc + 1;
          end else begin
            rd_val = mem_rd(mb_addr);
            rd_due = cyc + RD_LAT;
            pend_rdata = rd_val;
            mb_rsp_cyc = cyc + 1 + RD_LAT;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else begin
          mb_stall++;
          if (mb_stall == TO) begin
            mb_to = 1;
            mb_rsp_cyc = cyc + 1;
            pend_rdata = '0;
            pend_err = 1;
          end
        end
`endif
      end
      if (exp_rsp != '0) mb_busy = 0;
      if (g >= 0) begin
        mb_busy = 1; mb_owner = g; mb_T = cyc; mb_ptr = g;
        mb_hs = 0; mb_to = 0; mb_stall = 0; mb_rsp_cyc = -1;
        mb_we    = req_we[g];
        mb_addr  = req_addr[g*AW +: AW];
        mb_wdata = req_wdata[g*DW +: DW];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = 1'b1;
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  // Bounded wait for requester i to be accepted; returns one cycle after the accept
  task automatic serve(input int i);
    bit found;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      #2;
      if (req_ready[i]) found = 1;
      tick();
    end
    chk("serve_accept", found, 1);
    req_valid[i] = 1'b0;
  endtask

  initial begin
    int got;
    int stall_left;
    logic [N_REQ-1:0] acc;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; m_ready = 1'b1;
    repeat (3) tick();
    chk("reset_m_valid", m_valid, 0);
    chk("reset_m_we", m_we, 0);
    chk("reset_m_addr", m_addr, 0);
    chk("reset_m_wdata", m_wdata, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    chk("reset_rsp_err", rsp_err, 0);
    rst = 1'b0;
    tick();

    // Single write from requester 0
    set_req(0, 1'b1, 32'h10, 32'hDEADBEEF);
    #2 chk("t1_ready", req_ready, 4'b0001);
    tick(); req_valid = '0;
    #2 chk("t1_m_valid", m_valid, 1);
    chk("t1_m_addr", m_addr, 32'h10);
    chk("t1_m_wdata", m_wdata, 32'hDEADBEEF);
    tick();
    #2 chk("t1_rsp_valid", rsp_valid, 4'b0001);
    chk("t1_rsp_err", rsp_err, 0);

    // Read back from requester 2
    tick();
    set_req(2, 1'b0, 32'h10, 32'h0);
    #2 chk("t2_ready", req_ready, 4'b0100);
    tick(); req_valid = '0;
    tick();
    #2 chk("t2_wait_rsp", rsp_valid, 4'b0000);
    tick();
    #2 chk("t2_rsp_valid", rsp_valid, 4'b0100);
    chk("t2_rsp_rdata", rsp_rdata, 32'hDEADBEEF);

    // Fairness with everybody requesting
    do_reset(2);
    tick();
    for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, AW'(32'h100 + i * 4), $urandom);
    got = 0;
    for (int b = 0; b < 100 && got < 8; b++) begin
      #2;
      acc = req_ready;
      if (acc != '0) begin
        chk("fair_grant", acc, 64'(1) << (got % N_REQ));
        got++;
      end
      tick();
      for (int i = 0; i < N_REQ; i++) if (acc[i]) req_wdata[i*DW +: DW] = $urandom;
    end
    chk("fair_count", got, 8);
    req_valid = '0;
    repeat (4) tick();

    // Downstream stall for 5 cycles
    set_req(0, 1'b1, 32'h20, 32'h12345678);
    m_ready = 1'b0;
    #2 chk("t4_ready", req_ready, 4'b0001);
    tick(); req_valid[0] = 1'b0;
    set_req(1, 1'b0, 32'h20, 32'h0);
    for (int k = 0; k < 5; k++) begin
      #2 chk("t4_m_valid", m_valid, 1);
      chk("t4_m_addr", m_addr, 32'h20);
      chk("t4_m_wdata", m_wdata, 32'h12345678);
      chk("t4_no_ready", req_ready, 0);
      tick();
    end
    m_ready = 1'b1;
    #2 chk("t4_hs_m_valid", m_valid, 1);
    tick();
    #2 chk("t4_rsp_valid", rsp_valid, 4'b0001);
    chk("t4_resp_no_ready", req_ready, 0);
    req_valid[1] = 1'b0;
    tick();
    #2 chk("t4_dropped", req_ready, 0);
    repeat (2) tick();

    // Reset while waiting for read data
    do_reset(1);
    set_req(3, 1'b0, 32'h10, 32'h0);
    #2 chk("t5_ready", req_ready, 4'b1000);
    tick(); req_valid = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #2 chk("t5_m_valid", m_valid, 0);
      chk("t5_no_rsp", rsp_valid, 0);
      tick();
    end
    set_req(1, 1'b1, 32'h30, 32'h1111);
    set_req(0, 1'b1, 32'h34, 32'h2222);
    #2 chk("t5_ptr_reset", req_ready, 4'b0001);
    tick(); req_valid[0] = 1'b0;
    serve(1);
    repeat (4) tick();

`ifdef ARB_TIMEOUT_EN
    // Timeout with the slave never ready
    set_req(1, 1'b1, 32'h40, 32'hCAFE0001);
    m_ready = 1'b0;
    #2 chk("t6_ready", req_ready, 4'b0010);
    tick(); req_valid = '0;
    for (int k = 0; k < TO; k++) begin
      #2 chk("t6_m_valid_hi", m_valid, 1);
      tick();
    end
    #2 chk("t6_m_valid_lo", m_valid, 0);
    chk("t6_rsp_valid", rsp_valid, 4'b0010);
    chk("t6_rsp_err", rsp_err, 1);
    chk("t6_rsp_rdata", rsp_rdata, 0);
    m_ready = 1'b1;
    repeat (3) tick();
`endif

    // Randomized traffic, checked by the model
    acc = '0;
    stall_left = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < N_REQ; i++) begin
        if (acc[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 3) == 0)
          set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15) * 4), $urandom);
        else if (req_valid[i] && !acc[i] && $urandom_range(0, 29) == 0)
          req_valid[i] = 1'b0;
      end
      if (stall_left > 0) begin
        m_ready = 1'b0;
        stall_left--;
      end else begin
        m_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 199) == 0) stall_left = 20;
      end
      rst = ($urandom_range(0, 499) == 0);
      #2;
      acc = rst ? '0 : req_ready;
    end
    rst = 1'b0;
    req_valid = '0;
    m_ready = 1'b1;
    repeat (30) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    n_bad++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
